trace_arbiter: RTL and testbench

Sequencer and arbiter in front of the single-port `trace_buffer` column store. Shares one memory port between two requesters: the tracer, which writes one height/side trace per screen column during a frame fill, and the display scanline reader, which reads columns back in real time. Display reads always win. The block tracks fill progress across the 640 columns and signals when a complete frame of traces is resident.

---
 rtl/trace_pkg.sv | 20 ++
 rtl/trace_fill_counter.sv | 48 ++++
 rtl/trace_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_trace_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
`default_nettype none
//==============================================================================
// Package  : trace_pkg
// Brief    : Shared constants and fill-state encoding for the trace column store.
// Revision : 1.0 - initial release
//==============================================================================
package trace_pkg;

    localparam int SCREEN_COLS    = 640;
    localparam int TRACE_COL_W    = 10;
    localparam int TRACE_HEIGHT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/trace_fill_counter.sv
`default_nettype none
//==============================================================================
// Module   : trace_fill_counter
// Brief    : Saturating count of accepted writes in a fill, completion detect
//            and the registered frame_done pulse.
// Revision : 1.0 - initial release
//==============================================================================
module trace_fill_counter #(
    parameter int COLS  = 640,
    parameter int COL_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_count,
    output logic [COL_W-1:0] o_count,
    output logic             o_last,
    output logic             o_done
);

    localparam logic [COL_W-1:0] c_FULL = COL_W'(COLS);
    localparam logic [COL_W-1:0] c_LAST = COL_W'(COLS - 1);

    logic [COL_W-1:0] r_count;
    logic             r_done;

    // A clear in the same cycle as a write takes precedence, so it can never complete a fill.
    assign o_last = i_count && !i_clear && (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= o_last;
            if (i_clear) begin
                r_count <= '0;
            end else if (i_count && (r_count != c_FULL)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_done  = r_done;

endmodule
`default_nettype wire

// File: rtl/trace_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : trace_arbiter
// Brief    : Single-port arbiter for the trace column store; display reads win
//            over tracer writes, and a fill FSM tracks frame completion.
// Options  : TRACE_ARB_COLCHECK_EN - drop out-of-range writes, flag col_err.
// Revision : 1.0 - initial release
//==============================================================================
module trace_arbiter
    import trace_pkg::*;
#(
    parameter int COLS  = SCREEN_COLS,
    parameter int COL_W = TRACE_COL_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [COL_W-1:0]          wr_column,
    input  logic [TRACE_HEIGHT_W-1:0] wr_height,
    input  logic                      wr_side,
    input  logic                      rd_req,
    input  logic [COL_W-1:0]          rd_column,
    output logic                      rd_valid,
    output logic [TRACE_HEIGHT_W-1:0] rd_height,
    output logic                      rd_side,
    output logic                      mem_cs,
    output logic                      mem_we,
    output logic                      mem_oe,
    output logic [COL_W-1:0]          mem_column,
    output logic [TRACE_HEIGHT_W-1:0] mem_wheight,
    output logic                      mem_wside,
    input  logic [TRACE_HEIGHT_W-1:0] mem_rheight,
    input  logic                      mem_rside,
    output logic [1:0]                fill_state,
    output logic                      frame_done,
    output logic [COL_W-1:0]          wr_count
`ifdef TRACE_ARB_COLCHECK_EN
    ,
    output logic                      col_err
`endif
);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_FILL  = FILL;
    localparam logic [1:0] c_ST_READY = READY;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic                      w_rd_grant;
    logic                      w_wr_accept;
    logic                      w_wr_issue;
    logic                      w_wr_count;
    logic                      w_fill_last;
    logic [COL_W-1:0]          r_col_hold;
    logic [TRACE_HEIGHT_W-1:0] r_wheight_hold;
    logic                      r_wside_hold;
    logic                      r_rd_valid;
    logic [TRACE_HEIGHT_W-1:0] r_rd_height;
    logic                      r_rd_side;

    assign w_rd_grant  = rd_req;
    assign wr_ready    = (r_state == c_ST_FILL) && !rd_req;
    assign w_wr_accept = wr_valid && wr_ready;

`ifdef TRACE_ARB_COLCHECK_EN
    localparam logic [COL_W:0] c_COLS_EXT = (COL_W + 1)'(COLS);

    logic w_col_bad;
    logic r_col_err;

    assign w_col_bad  = ({1'b0, wr_column} >= c_COLS_EXT);
    // Bad columns still complete the handshake so the tracer never stalls on them.
    assign w_wr_issue = w_wr_accept && !w_col_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_err <= 1'b0;
        end else if (frame_start) begin
            r_col_err <= 1'b0;
        end else if (w_wr_accept && w_col_bad) begin
            r_col_err <= 1'b1;
        end
    end

    assign col_err = r_col_err;
`else
    assign w_wr_issue = w_wr_accept;
`endif

    // The write still reaches memory when frame_start coincides, but it starts no count.
    assign w_wr_count = w_wr_issue && !frame_start;

    trace_fill_counter #(
        .COLS  (COLS),
        .COL_W (COL_W)
    ) u_fill_counter (
        .clk     (clk),
        .rst     (reset),
        .i_clear (frame_start),
        .i_count (w_wr_count),
        .o_count (wr_count),
        .o_last  (w_fill_last),
        .o_done  (frame_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (frame_start) w_state_nxt = c_ST_FILL;
            c_ST_FILL: begin
                if (frame_start) begin
                    w_state_nxt = c_ST_FILL;
                end else if (w_fill_last) begin
                    w_state_nxt = c_ST_READY;
                end
            end
            c_ST_READY: if (frame_start) w_state_nxt = c_ST_FILL;
            default:    w_state_nxt = frame_start ? c_ST_FILL : c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign fill_state = r_state;

    // Strobes are combinational so the memory acts in the granted cycle itself.
    always_comb begin
        mem_cs      = w_rd_grant || w_wr_issue;
        mem_we      = w_wr_issue && !w_rd_grant;
        mem_oe      = w_rd_grant;
        mem_column  = r_col_hold;
        mem_wheight = r_wheight_hold;
        mem_wside   = r_wside_hold;
        if (w_rd_grant) begin
            mem_column = rd_column;
        end else if (w_wr_issue) begin
            mem_column = wr_column;
        end
        if (w_wr_issue) begin
            mem_wheight = wr_height;
            mem_wside   = wr_side;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_hold     <= '0;
            r_wheight_hold <= '0;
            r_wside_hold   <= 1'b0;
        end else begin
            if (mem_cs) begin
                r_col_hold <= mem_column;
            end
            if (w_wr_issue) begin
                r_wheight_hold <= wr_height;
                r_wside_hold   <= wr_side;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid  <= 1'b0;
            r_rd_height <= '0;
            r_rd_side   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_grant;
            if (w_rd_grant) begin
                r_rd_height <= mem_rheight;
                r_rd_side   <= mem_rside;
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_height = r_rd_height;
    assign rd_side   = r_rd_side;

endmodule
`default_nettype wire

// File: tb/tb_trace_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_trace_arbiter
// Brief    : Self-checking bench for trace_arbiter against a behavioural model.
// Options  : TRACE_ARB_COLCHECK_EN
// Revision : 1.0 - initial release
//==============================================================================
module tb_trace_arbiter;

    localparam int COLS  = 640;
    localparam int COL_W = 10;
    localparam int DEPTH = 2 ** COL_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, frame_start, wr_valid, wr_side, rd_req;
    logic [COL_W-1:0] wr_column, rd_column;
    logic [7:0]       wr_height;
    logic             wr_ready, rd_valid, rd_side, mem_cs, mem_we, mem_oe, mem_wside, mem_rside;
    logic [7:0]       rd_height, mem_wheight, mem_rheight;
    logic [COL_W-1:0] mem_column, wr_count;
    logic [1:0]       fill_state;
    logic             frame_done;
`ifdef TRACE_ARB_COLCHECK_EN
    logic             col_err;
`endif

    trace_arbiter #(.COLS(COLS), .COL_W(COL_W)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_column(wr_column),
        .wr_height(wr_height), .wr_side(wr_side),
        .rd_req(rd_req), .rd_column(rd_column), .rd_valid(rd_valid),
        .rd_height(rd_height), .rd_side(rd_side),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_column(mem_column),
        .mem_wheight(mem_wheight), .mem_wside(mem_wside),
        .mem_rheight(mem_rheight), .mem_rside(mem_rside),
        .fill_state(fill_state), .frame_done(frame_done), .wr_count(wr_count)
`ifdef TRACE_ARB_COLCHECK_EN
        , .col_err(col_err)
`endif
    );

    // Physical column store driven by the DUT strobes (asynchronous read).
    logic [7:0] phys_h [DEPTH];
    logic       phys_s [DEPTH];
    assign mem_rheight = (mem_cs && mem_oe) ? phys_h[mem_column] : 8'h00;
    assign mem_rside   = (mem_cs && mem_oe) ? phys_s[mem_column] : 1'b0;
    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            phys_h[mem_column] <= mem_wheight;
            phys_s[mem_column] <= mem_wside;
        end
    end

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: expected memory, fill progress and registered outputs.
    int m_mem_h [DEPTH];
    int m_mem_s [DEPTH];
    int m_state = 0, m_count = 0, m_col = 0, m_wh = 0, m_ws = 0, m_rd_h = 0, m_rd_s = 0;
    bit m_done = 0, m_rd_valid = 0, m_col_err = 0;
    bit e_wr_ready, e_acc, e_rd, e_wr;

    always_comb begin
        e_wr_ready = (m_state == 1) && !rd_req;
        e_acc      = wr_valid && e_wr_ready;
        e_rd       = rd_req;
        e_wr       = e_acc;
`ifdef TRACE_ARB_COLCHECK_EN
        if (int'(wr_column) >= COLS) e_wr = 1'b0;
`endif
    end

    always @(posedge clk) begin
        bit rd, wr, acc;
        int rc, wc;
        rd = e_rd; wr = e_wr; acc = e_acc;
        rc = int'(rd_column); wc = int'(wr_column);
        if (wr) begin
            m_mem_h[wc] = int'(wr_height);
            m_mem_s[wc] = int'(wr_side);
        end
        if (reset) begin
            m_state = 0; m_count = 0; m_done = 0; m_rd_valid = 0;
            m_rd_h = 0; m_rd_s = 0; m_col = 0; m_wh = 0; m_ws = 0; m_col_err = 0;
        end else begin
            m_done     = 0;
            m_rd_valid = rd;
            if (rd) begin
                m_rd_h = m_mem_h[rc];
                m_rd_s = m_mem_s[rc];
                m_col  = rc;
            end else if (wr) begin
                m_col = wc;
            end
            if (wr) begin
                m_wh = int'(wr_height);
                m_ws = int'(wr_side);
            end
            if (frame_start) begin
                m_state = 1; m_count = 0; m_col_err = 0;
            end else begin
                if (wr && m_count < COLS) begin
                    m_count++;
                    if (m_count == COLS) begin
                        m_state = 2;
                        m_done  = 1;
                    end
                end
                if (acc && !wr) m_col_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_ready", int'(wr_ready), int'(e_wr_ready));
            chk("mem_cs", int'(mem_cs), int'(e_rd || e_wr));
            chk("mem_we", int'(mem_we), int'(e_wr));
            chk("mem_oe", int'(mem_oe), int'(e_rd));
            chk("mem_column", int'(mem_column),
                e_rd ? int'(rd_column) : (e_wr ? int'(wr_column) : m_col));
            chk("mem_wheight", int'(mem_wheight), e_wr ? int'(wr_height) : m_wh);
            chk("mem_wside", int'(mem_wside), e_wr ? int'(wr_side) : m_ws);
            chk("rd_valid", int'(rd_valid), int'(m_rd_valid));
            chk("rd_height", int'(rd_height), m_rd_h);
            chk("rd_side", int'(rd_side), m_rd_s);
            chk("fill_state", int'(fill_state), m_state);
            chk("frame_done", int'(frame_done), int'(m_done));
            chk("wr_count", int'(wr_count), m_count);
`ifdef TRACE_ARB_COLCHECK_EN
            chk("col_err", int'(col_err), int'(m_col_err));
`endif
            if (frame_done) done_seen++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_start = 0; wr_valid = 0; rd_req = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int v, acc, done_before;
        for (int i = 0; i < DEPTH; i++) begin
            v = int'($urandom_range(0, 511));
            phys_h[i] = v[7:0]; phys_s[i] = v[8];
            m_mem_h[i] = int'(v[7:0]); m_mem_s[i] = int'(v[8]);
        end
        reset = 1; idle_inputs();
        wr_column = '0; rd_column = '0; wr_height = '0; wr_side = 0;
        cyc();
        chk_en = 1;
        cyc(); cyc();
        reset = 0;
        cyc();

        // Idle: writes blocked, no memory strobe.
        chk("rst_state", int'(fill_state), 0);
        chk("rst_count", int'(wr_count), 0);
        wr_valid = 1; wr_column = 10'd4; #1;
        chk("idle_wr_ready", int'(wr_ready), 0);
        chk("idle_mem_cs", int'(mem_cs), 0);
        wr_valid = 0;

        // Full fill of columns 0..639.
        frame_start = 1; cyc(); frame_start = 0;
        done_before = done_seen;
        for (int i = 0; i < COLS; i++) begin
            wr_valid = 1; wr_column = COL_W'(i);
            wr_height = 8'($urandom); wr_side = 1'($urandom);
            cyc();
        end
        wr_valid = 0;
        chk("fill_done_pulse", int'(frame_done), 1);
        chk("fill_ready", int'(fill_state), 2);
        chk("fill_count", int'(wr_count), 640);
        cyc();
        chk("fill_done_once", done_seen, done_before + 1);
        chk("fill_done_clear", int'(frame_done), 0);

        // Read/write collision and read-back of column 5.
        frame_start = 1; cyc(); frame_start = 0;
        wr_valid = 1; wr_column = 10'd5; wr_height = 8'h3C; wr_side = 1;
        rd_req = 1; rd_column = 10'd7; #1;
        chk("coll_wr_ready", int'(wr_ready), 0);
        chk("coll_mem_oe", int'(mem_oe), 1);
        cyc(); rd_req = 0; #1;
        chk("coll_wr_ready2", int'(wr_ready), 1);
        chk("coll_mem_we", int'(mem_we), 1);
        chk("coll_mem_col", int'(mem_column), 5);
        cyc(); wr_valid = 0; rd_req = 1; rd_column = 10'd5;
        cyc(); rd_req = 0;
        chk("rd5_valid", int'(rd_valid), 1);
        chk("rd5_height", int'(rd_height), 8'h3C);
        chk("rd5_side", int'(rd_side), 1);

        // frame_start coinciding with an accepted write: write lands, not counted.
        wr_valid = 1; wr_column = 10'd9; wr_height = 8'hA5; wr_side = 0; frame_start = 1;
        cyc(); frame_start = 0; wr_valid = 0;
        chk("fs_wr_count", int'(wr_count), 0);
        chk("fs_state", int'(fill_state), 1);
        rd_req = 1; rd_column = 10'd9; cyc(); rd_req = 0;
        chk("fs_rd_height", int'(rd_height), 8'hA5);

        // Abort after 300 writes, then complete with interleaved reads.
        for (int i = 0; i < 300; i++) begin
            wr_valid = 1; wr_column = COL_W'(i); wr_height = 8'($urandom); wr_side = 1'($urandom);
            cyc();
        end
        wr_valid = 0;
        chk("abort_pre", int'(wr_count), 300);
        done_before = done_seen;
        frame_start = 1; cyc(); frame_start = 0;
        chk("abort_count", int'(wr_count), 0);
        acc = 0;
        for (int c = 0; c < 2000 && acc < COLS; c++) begin
            rd_req = ($urandom_range(0, 3) == 0); rd_column = COL_W'($urandom_range(0, COLS - 1));
            wr_valid = 1; wr_column = COL_W'(acc); wr_height = 8'($urandom); wr_side = 1'($urandom);
            cyc();
            if (!rd_req) acc++;
        end
        idle_inputs();
        chk("abort_no_done", done_seen, done_before);
        chk("refill_done", int'(frame_done), 1);
        chk("refill_count", int'(wr_count), 640);
        chk("refill_state", int'(fill_state), 2);

        // Reset the cycle after a read grant.
        rd_req = 1; rd_column = 10'd3; cyc();
        rd_req = 0; reset = 1;
        chk("rst_rd_inflight", int'(rd_valid), 1);
        cyc(); reset = 0;
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_fill_state", int'(fill_state), 0);

`ifdef TRACE_ARB_COLCHECK_EN
        frame_start = 1; cyc(); frame_start = 0;
        wr_valid = 1; wr_column = 10'd700; wr_height = 8'h11; #1;
        chk("cc_wr_ready", int'(wr_ready), 1);
        chk("cc_mem_we", int'(mem_we), 0);
        cyc(); wr_valid = 0;
        chk("cc_col_err", int'(col_err), 1);
        chk("cc_count", int'(wr_count), 0);
`endif

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 599) == 0);
            frame_start = ($urandom_range(0, 1199) == 0) || (c == 0);
            wr_valid    = ($urandom_range(0, 9) < 7);
            rd_req      = ($urandom_range(0, 9) < 3);
            rd_column   = COL_W'($urandom_range(0, DEPTH - 1));
            wr_column   = ($urandom_range(0, 19) == 0) ? COL_W'($urandom_range(COLS, DEPTH - 1))
                                                      : COL_W'($urandom_range(0, COLS - 1));
            wr_height   = 8'($urandom);
            wr_side     = 1'($urandom);
            cyc();
        end
        reset = 0; idle_inputs();
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
